platform_boot_ctrl: RTL and testbench

Sequencer that owns the virtual platform's control pins. It streams a ROM image byte-by-byte into the platform over the sw_addr/sw_din/we_n/mode load port, then drops to run mode and pulses the platform reset. After that it bridges the platform's din_req/din_rdy and dout_rdy handshakes to valid/ready host streams. It sits between the host or test harness and the top_level platform instance, replacing the hand-written load/run sequencing.

---
 rtl/platform_boot_ctrl_pkg.sv | 22 ++
 rtl/platform_boot_ctrl_platform_io_bridge.sv | 93 +++++++++
 rtl/platform_boot_ctrl.sv | 171 +++++++++++++++++
 tb/tb_platform_boot_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/platform_boot_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// platform_boot_ctrl_pkg
//   Shared definitions for the platform boot sequencer: the sequencer state
//   type and default geometry of the ROM image and platform data path.
// ----------------------------------------------------------------------------
package platform_boot_ctrl_pkg;

  // Sequencer phases: wait for start, stream the image, hold the platform in
  // reset in run mode, then bridge host streams to the running platform.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PRST = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  localparam int DEF_ROM_SIZE   = 16384;
  localparam int DEF_ADDR_W     = 14;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_RST_CYCLES = 1;

endpackage

// File: rtl/platform_boot_ctrl_platform_io_bridge.sv
// ----------------------------------------------------------------------------
// platform_io_bridge
//   Run-phase bridge between the platform's din_req/din_rdy and dout_rdy
//   handshakes and valid/ready host streams.
//
//   Ports:
//     i_clk, i_rst          clock, synchronous active-high reset
//     i_en                  bridge active (sequencer in RUN)
//     i_host_din[_valid]    host word offered to the platform
//     o_host_din_ready      one-cycle accept strobe (combinational)
//     o_host_dout[_valid]   captured platform output, pending flag
//     i_host_dout_ready     host consumes o_host_dout
//     o_din, o_din_rdy      word presented to the platform, valid flag
//     i_din_req             platform requests a word
//     i_dout, i_dout_rdy    platform output word, level valid
//     o_overrun             sticky: a platform output was dropped
// ----------------------------------------------------------------------------
module platform_io_bridge #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_host_din,
  input  logic              i_host_din_valid,
  output logic              o_host_din_ready,
  output logic [DATA_W-1:0] o_host_dout,
  output logic              o_host_dout_valid,
  input  logic              i_host_dout_ready,
  output logic [DATA_W-1:0] o_din,
  output logic              o_din_rdy,
  input  logic              i_din_req,
  input  logic [DATA_W-1:0] i_dout,
  input  logic              i_dout_rdy,
  output logic              o_overrun
);

  logic [DATA_W-1:0] r_din;
  logic              r_din_rdy;
  logic [DATA_W-1:0] r_host_dout;
  logic              r_host_dout_valid;
  logic              r_overrun;
  logic              r_dout_rdy_q;
  logic              w_take;
  logic              w_edge;

  // A new word is only taken while no word is outstanding to the platform.
  assign w_take = i_en & i_din_req & ~r_din_rdy & i_host_din_valid;

  // dout_rdy is a level; only its rising edge marks a fresh output word.
  assign w_edge = i_en & i_dout_rdy & ~r_dout_rdy_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_din             <= '0;
      r_din_rdy         <= 1'b0;
      r_host_dout       <= '0;
      r_host_dout_valid <= 1'b0;
      r_overrun         <= 1'b0;
      r_dout_rdy_q      <= 1'b0;
    end else begin
      r_dout_rdy_q <= i_dout_rdy;

      if (w_take) begin
        r_din     <= i_host_din;
        r_din_rdy <= 1'b1;
      end else if (i_en && !i_din_req) begin
        r_din_rdy <= 1'b0;
      end

      if (w_edge) begin
        // A pending word that the host is not consuming this cycle wins;
        // the new word is dropped and recorded as an overrun.
        if (r_host_dout_valid && !i_host_dout_ready) begin
          r_overrun <= 1'b1;
        end else begin
          r_host_dout       <= i_dout;
          r_host_dout_valid <= 1'b1;
        end
      end else if (i_en && i_host_dout_ready) begin
        r_host_dout_valid <= 1'b0;
      end
    end
  end

  assign o_host_din_ready  = w_take;
  assign o_din             = r_din;
  assign o_din_rdy         = r_din_rdy;
  assign o_host_dout       = r_host_dout;
  assign o_host_dout_valid = r_host_dout_valid;
  assign o_overrun         = r_overrun;

endmodule

// File: rtl/platform_boot_ctrl.sv
// ----------------------------------------------------------------------------
// platform_boot_ctrl
//   Owns the virtual platform's control pins. Streams a ROM image byte by
//   byte over the sw_addr/sw_din/we_n load port while mode=1, then switches
//   to run mode, holds plat_rst for RST_CYCLES cycles and releases the
//   platform. In RUN the platform_io_bridge connects host streams to the
//   platform's din/dout handshakes.
//
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     start                        begin image load (IDLE only)
//     img_data/img_valid/img_ready ROM image byte stream
//     host_din/_valid/_ready       host -> platform word stream
//     host_dout/_valid/_ready      platform -> host word stream
//     sw_addr, sw_din, we_n, mode  platform ROM load port
//     plat_rst                     platform reset
//     din, din_rdy, din_req        platform input handshake
//     dout, dout_rdy               platform output handshake
//     busy, load_done, overrun     status
// ----------------------------------------------------------------------------
module platform_boot_ctrl
  import platform_boot_ctrl_pkg::*;
#(
  parameter int ROM_SIZE   = DEF_ROM_SIZE,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RST_CYCLES = DEF_RST_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        img_data,
  input  logic              img_valid,
  output logic              img_ready,
  input  logic [DATA_W-1:0] host_din,
  input  logic              host_din_valid,
  output logic              host_din_ready,
  output logic [DATA_W-1:0] host_dout,
  output logic              host_dout_valid,
  input  logic              host_dout_ready,
  output logic [ADDR_W-1:0] sw_addr,
  output logic [7:0]        sw_din,
  output logic              we_n,
  output logic              mode,
  output logic              plat_rst,
  output logic [DATA_W-1:0] din,
  output logic              din_rdy,
  input  logic              din_req,
  input  logic [DATA_W-1:0] dout,
  input  logic              dout_rdy,
  output logic              busy,
  output logic              load_done,
  output logic              overrun
);

  localparam int                RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROM_SIZE - 1);
  localparam logic [RCW-1:0]    RST_LAST = RCW'(RST_CYCLES - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_full;
  logic [RCW-1:0]    r_rcnt;
  logic [ADDR_W-1:0] r_sw_addr;
  logic [7:0]        r_sw_din;
  logic              r_we_n;
  logic              r_mode;
  logic              r_plat_rst;
  logic              r_busy;
  logic              r_load_done;

  logic              w_accept;
  logic              w_run;

  // r_full marks that the last byte has been accepted; the port closes while
  // that final byte is still being written.
  assign img_ready = (r_state == ST_LOAD) && !r_full;
  assign w_accept  = img_ready && img_valid;
  assign w_run     = (r_state == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_full      <= 1'b0;
      r_rcnt      <= '0;
      r_sw_addr   <= '0;
      r_sw_din    <= '0;
      r_we_n      <= 1'b1;
      r_mode      <= 1'b1;
      r_plat_rst  <= 1'b1;
      r_busy      <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_we_n <= 1'b1;

      if (w_accept) begin
        r_sw_addr <= r_cnt;
        r_sw_din  <= img_data;
        r_we_n    <= 1'b0;
        r_cnt     <= r_cnt + ADDR_W'(1);
        if (r_cnt == LAST_IDX) begin
          r_full <= 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          // r_full here means the final write is on the port this cycle.
          if (r_full) begin
            r_state <= ST_PRST;
            r_mode  <= 1'b0;
            r_rcnt  <= '0;
          end
        end
        ST_PRST: begin
          if (r_rcnt == RST_LAST) begin
            r_state     <= ST_RUN;
            r_plat_rst  <= 1'b0;
            r_load_done <= 1'b1;
          end else begin
            r_rcnt <= r_rcnt + RCW'(1);
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  platform_io_bridge #(
    .DATA_W(DATA_W)
  ) u_bridge (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_en              (w_run),
    .i_host_din        (host_din),
    .i_host_din_valid  (host_din_valid),
    .o_host_din_ready  (host_din_ready),
    .o_host_dout       (host_dout),
    .o_host_dout_valid (host_dout_valid),
    .i_host_dout_ready (host_dout_ready),
    .o_din             (din),
    .o_din_rdy         (din_rdy),
    .i_din_req         (din_req),
    .i_dout            (dout),
    .i_dout_rdy        (dout_rdy),
    .o_overrun         (overrun)
  );

  assign sw_addr   = r_sw_addr;
  assign sw_din    = r_sw_din;
  assign we_n      = r_we_n;
  assign mode      = r_mode;
  assign plat_rst  = r_plat_rst;
  assign busy      = r_busy;
  assign load_done = r_load_done;

endmodule

// File: tb/tb_platform_boot_ctrl.sv
module tb_platform_boot_ctrl;

  localparam int ROM_SIZE   = 16;
  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 32;
  localparam int RST_CYCLES = 1;

  logic              clk = 1'b0;
  logic              rst, start, img_valid, host_din_valid, host_dout_ready;
  logic              din_req, dout_rdy;
  logic [7:0]        img_data;
  logic [DATA_W-1:0] host_din, dout;
  logic              img_ready, host_din_ready, host_dout_valid, we_n, mode;
  logic              plat_rst, din_rdy, busy, load_done, overrun;
  logic [DATA_W-1:0] host_dout, din;
  logic [ADDR_W-1:0] sw_addr;
  logic [7:0]        sw_din;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  platform_boot_ctrl #(
    .ROM_SIZE(ROM_SIZE), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .img_data(img_data), .img_valid(img_valid), .img_ready(img_ready),
    .host_din(host_din), .host_din_valid(host_din_valid), .host_din_ready(host_din_ready),
    .host_dout(host_dout), .host_dout_valid(host_dout_valid), .host_dout_ready(host_dout_ready),
    .sw_addr(sw_addr), .sw_din(sw_din), .we_n(we_n), .mode(mode), .plat_rst(plat_rst),
    .din(din), .din_rdy(din_rdy), .din_req(din_req),
    .dout(dout), .dout_rdy(dout_rdy),
    .busy(busy), .load_done(load_done), .overrun(overrun)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase name plus counts of accepted bytes and remaining
  // reset cycles; expected outputs updated from inputs seen at each edge.
  int          m_phase;   // 0 idle, 1 loading, 2 platform reset, 3 running
  int          m_acc;
  int          m_prst;
  bit          m_ok = 0;
  logic        m_mode, m_plat_rst, m_we_n, m_din_rdy, m_hdv, m_ovr, m_busy, m_ld, m_prev;
  logic [3:0]  m_addr;
  logic [7:0]  m_sdin;
  logic [31:0] m_din, m_hd;

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1; m_phase = 0; m_acc = 0; m_prst = 0;
      m_mode = 1; m_plat_rst = 1; m_we_n = 1; m_din_rdy = 0; m_hdv = 0;
      m_ovr = 0; m_busy = 0; m_ld = 0; m_prev = 0;
      m_addr = '0; m_sdin = '0; m_din = '0; m_hd = '0;
    end else if (m_ok) begin
      bit acc, take, rise, all_in;
      all_in = (m_phase == 1) && (m_acc == ROM_SIZE);
      acc    = (m_phase == 1) && (m_acc < ROM_SIZE) && img_valid;
      take   = (m_phase == 3) && din_req && !m_din_rdy && host_din_valid;
      rise   = dout_rdy && !m_prev;
      m_we_n = 1;
      if (acc) begin
        m_addr = 4'(m_acc); m_sdin = img_data; m_we_n = 0; m_acc++;
      end
      case (m_phase)
        0: if (start) begin m_phase = 1; m_acc = 0; m_busy = 1; end
        1: if (all_in) begin m_phase = 2; m_mode = 0; m_prst = RST_CYCLES; end
        2: begin
          m_prst--;
          if (m_prst == 0) begin m_phase = 3; m_plat_rst = 0; m_ld = 1; end
        end
        default: begin
          if (take) begin m_din = host_din; m_din_rdy = 1; end
          else if (!din_req) m_din_rdy = 0;
          if (rise) begin
            if (m_hdv && !host_dout_ready) m_ovr = 1;
            else begin m_hd = dout; m_hdv = 1; end
          end else if (host_dout_ready) m_hdv = 0;
        end
      endcase
      m_prev = dout_rdy;
    end
  end

  // Per-cycle comparison, mid-cycle, once the model has seen a reset.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("mode", mode, m_mode);
      chk("plat_rst", plat_rst, m_plat_rst);
      chk("we_n", we_n, m_we_n);
      chk("sw_addr", sw_addr, m_addr);
      chk("sw_din", sw_din, m_sdin);
      chk("img_ready", img_ready, (m_phase == 1) && (m_acc < ROM_SIZE));
      chk("host_din_ready", host_din_ready,
          (m_phase == 3) && din_req && !m_din_rdy && host_din_valid);
      chk("din", din, m_din);
      chk("din_rdy", din_rdy, m_din_rdy);
      chk("host_dout", host_dout, m_hd);
      chk("host_dout_valid", host_dout_valid, m_hdv);
      chk("overrun", overrun, m_ovr);
      chk("busy", busy, m_busy);
      chk("load_done", load_done, m_ld);
    end
  end

  // Observation of the load port and strobes for the literal checks.
  int         cyc_n = 0;
  logic [11:0] wq[$];
  int         wcyc[$];
  int         prst_cnt = 0;
  int         take_cnt = 0;

  always @(posedge clk) cyc_n++;
  always @(negedge clk) begin
    if (m_ok && we_n === 1'b0) begin
      wq.push_back({sw_addr, sw_din});
      wcyc.push_back(cyc_n);
    end
    if (m_ok && mode === 1'b0 && plat_rst === 1'b1) prst_cnt++;
    if (m_ok && host_din_ready === 1'b1) take_cnt++;
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic idle_inputs();
    start = 0; img_valid = 0; img_data = '0; host_din = '0; host_din_valid = 0;
    host_dout_ready = 0; din_req = 0; dout = '0; dout_rdy = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; cyc(); cyc(); rst = 0;
  endtask

  task automatic begin_load();
    wq.delete(); wcyc.delete(); prst_cnt = 0;
    start = 1; cyc(); start = 0;
  endtask

  // pace: 0 continuous, 1 every third cycle, 2 random
  task automatic load_image(input int pace, input int stop_at);
    int b = 0;
    int guard = 0;
    while (b < stop_at && guard < 400) begin
      img_data  = 8'(b);
      img_valid = (pace == 0) ? 1'b1 : (pace == 1) ? (guard % 3 == 0) : 1'($urandom % 2);
      #1;
      if (img_valid && img_ready) b++;
      @(posedge clk); #2;
      guard++;
    end
    img_valid = 0;
    chk("bytes_accepted", b, stop_at);
  endtask

  task automatic wait_run();
    for (int i = 0; i < 20 && !load_done; i++) cyc();
    chk("reached_run", load_done, 1);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwrites"}, wq.size(), ROM_SIZE);
    for (int i = 0; i < wq.size() && i < ROM_SIZE; i++) begin
      chk({tag, "_waddr"}, wq[i][11:8], i);
      chk({tag, "_wdata"}, wq[i][7:0], i);
    end
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      start           = ($urandom % 16 == 0);
      img_valid       = 1'($urandom % 2);
      img_data        = 8'($urandom);
      din_req         = ($urandom % 4 != 0);
      host_din_valid  = 1'($urandom % 2);
      host_din        = $urandom;
      dout            = $urandom;
      dout_rdy        = ($urandom % 3 == 0);
      host_dout_ready = ($urandom % 3 == 0);
      cyc();
    end
    idle_inputs();
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst = 1;
    repeat (3) cyc();
    chk("rst_mode", mode, 1);
    chk("rst_plat_rst", plat_rst, 1);
    chk("rst_we_n", we_n, 1);
    chk("rst_sw_addr", sw_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_img_ready", img_ready, 0);
    chk("rst_overrun", overrun, 0);
    rst = 0;
    cyc();

    // continuous image: back-to-back writes, then one reset cycle in run mode
    begin_load();
    load_image(0, ROM_SIZE);
    wait_run();
    check_writes("cont");
    chk("cont_span", wcyc[wcyc.size()-1] - wcyc[0], ROM_SIZE - 1);
    chk("cont_prst_cycles", prst_cnt, RST_CYCLES);
    chk("cont_mode_run", mode, 0);

    // start during RUN is ignored
    start = 1; cyc(); start = 0; cyc();
    chk("start_in_run_done", load_done, 1);
    chk("start_in_run_mode", mode, 0);

    // din handshake: one word taken, second held off while din_rdy=1
    take_cnt = 0;
    din_req = 1; host_din = 6; host_din_valid = 1;
    repeat (3) cyc();
    host_din = 7;
    repeat (3) cyc();
    chk("din_take_count", take_cnt, 1);
    chk("din_value", din, 6);
    chk("din_rdy_held", din_rdy, 1);
    din_req = 0; host_din_valid = 0;
    cyc(); cyc();
    chk("din_rdy_cleared", din_rdy, 0);

    // two dout edges with no consumer: first kept, second dropped
    dout = 32'h2A; dout_rdy = 1; cyc(); dout_rdy = 0; cyc();
    dout = 32'h2B; dout_rdy = 1; cyc(); dout_rdy = 0; cyc();
    chk("ovr_host_dout", host_dout, 32'h2A);
    chk("ovr_flag", overrun, 1);

    // throttled image: every write exactly one cycle after its accept
    do_reset();
    begin_load();
    load_image(1, ROM_SIZE);
    wait_run();
    check_writes("thr");
    chk("thr_span", wcyc[wcyc.size()-1] - wcyc[0], 3 * (ROM_SIZE - 1));

    // second edge coinciding with host_dout_ready: replaces, no overrun
    dout = 32'h2A; dout_rdy = 1; cyc(); dout_rdy = 0; cyc();
    dout = 32'h2B; dout_rdy = 1; host_dout_ready = 1; cyc();
    dout_rdy = 0; host_dout_ready = 0; cyc();
    chk("rdy_host_dout", host_dout, 32'h2B);
    chk("rdy_valid", host_dout_valid, 1);
    chk("rdy_overrun", overrun, 0);
    host_dout_ready = 1; cyc(); host_dout_ready = 0; cyc();
    chk("rdy_consumed", host_dout_valid, 0);

    // reset in the middle of a load, then reload from address 0
    do_reset();
    begin_load();
    load_image(0, 7);
    rst = 1; cyc();
    chk("mid_rst_mode", mode, 1);
    chk("mid_rst_plat_rst", plat_rst, 1);
    chk("mid_rst_we_n", we_n, 1);
    chk("mid_rst_sw_addr", sw_addr, 0);
    chk("mid_rst_sw_din", sw_din, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_img_ready", img_ready, 0);
    rst = 0; cyc();
    begin_load();
    load_image(0, ROM_SIZE);
    wait_run();
    check_writes("reload");

    // randomized traffic in RUN, then a randomly paced load and more traffic
    random_run(300);
    do_reset();
    begin_load();
    load_image(2, ROM_SIZE);
    wait_run();
    check_writes("rand");
    random_run(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
